// File: rtl/i2c_pkg.sv
// Constants and state encodings shared by the I2C slave and master controllers.
package i2c_pkg;

    localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'h55;
    localparam int unsigned SYNC_DEPTH = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_RD_ACK,
        ST_WAIT_STOP
    } state_t;

    // Register index width; a one-register file still needs a 1-bit index.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/i2c_slave_regfile_if.sv
// Register-file side of the I2C slave: contents, write-commit pulse and select flag.
interface i2c_slave_regfile_if
    import i2c_pkg::*;
#(
    parameter int unsigned NUM_REGS = 4
);
    localparam int unsigned IDX_W = idx_width(NUM_REGS);

    logic [8*NUM_REGS-1:0] regs_flat;
    logic                  wr_strobe;
    logic [IDX_W-1:0]      wr_index;
    logic [7:0]            wr_data;
    logic                  selected;

    modport slave (
        output regs_flat,
        output wr_strobe,
        output wr_index,
        output wr_data,
        output selected
    );

    modport master (
        input regs_flat,
        input wr_strobe,
        input wr_index,
        input wr_data,
        input selected
    );
endinterface

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizers plus an edge flop; derives SCL edges and START/STOP.
module i2c_bus_sync
    import i2c_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic scl,
    input  logic sda,
    output logic scl_s,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);
    logic [SYNC_DEPTH-1:0] scl_sync;
    logic [SYNC_DEPTH-1:0] sda_sync;
    logic                  scl_d;
    logic                  sda_d;

    // Reset to the idle (pulled-up) bus level so release from reset is quiet.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_DEPTH-2:0], scl};
            sda_sync <= {sda_sync[SYNC_DEPTH-2:0], sda};
            scl_d    <= scl_sync[SYNC_DEPTH-1];
            sda_d    <= sda_sync[SYNC_DEPTH-1];
        end
    end

    assign scl_s     = scl_sync[SYNC_DEPTH-1];
    assign sda_s     = sda_sync[SYNC_DEPTH-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C slave exposing a byte-wide register file with auto-incrementing pointer.
module i2c_slave_regfile
    import i2c_pkg::*;
#(
    parameter logic [6:0]  SLAVE_ADDR = DEFAULT_SLAVE_ADDR,
    parameter int unsigned NUM_REGS   = 4,
    parameter logic [7:0]  REG_RST    = 8'h00
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                scl,
    inout  wire                 sda,
    i2c_slave_regfile_if.slave  bus
);
    localparam int unsigned IDX_W = idx_width(NUM_REGS);

    logic scl_level_unused;
    logic sda_s;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    state_t           state;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift;
    logic [IDX_W-1:0] ptr;
    logic             rw;
    logic             ack_on;
    logic             sda_low;
    logic             selected;
    logic             wr_strobe_q;
    logic [IDX_W-1:0] wr_index_q;
    logic [7:0]       wr_data_q;

    logic [7:0]            regs [NUM_REGS];
    logic [8*NUM_REGS-1:0] regs_flat;

    i2c_bus_sync u_sync (
        .clk       (clk),
        .reset_n   (reset_n),
        .scl       (scl),
        .sda       (sda),
        .scl_s     (scl_level_unused),
        .sda_s     (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    assign sda = sda_low ? 1'b0 : 1'bz;

    // ack_on marks the second half of a two-fall ACK slot (drive, then release).
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            shift       <= '0;
            ptr         <= '0;
            rw          <= 1'b0;
            ack_on      <= 1'b0;
            sda_low     <= 1'b0;
            selected    <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_index_q  <= '0;
            wr_data_q   <= '0;
        end else begin
            wr_strobe_q <= 1'b0;
            if (start_det) begin
                state    <= ST_ADDR;
                bit_cnt  <= '0;
                ptr      <= '0;
                ack_on   <= 1'b0;
                sda_low  <= 1'b0;
                selected <= 1'b0;
            end else if (stop_det) begin
                state    <= ST_IDLE;
                ack_on   <= 1'b0;
                sda_low  <= 1'b0;
                selected <= 1'b0;
            end else begin
                unique case (state)
                    ST_ADDR: begin
                        if (scl_rise) begin
                            shift   <= {shift[6:0], sda_s};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if (shift[6:0] == SLAVE_ADDR) begin
                                    rw    <= sda_s;
                                    state <= ST_ADDR_ACK;
                                end else begin
                                    state <= ST_WAIT_STOP;
                                end
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (scl_fall) begin
                            if (!ack_on) begin
                                ack_on   <= 1'b1;
                                sda_low  <= 1'b1;
                                selected <= 1'b1;
                            end else begin
                                ack_on  <= 1'b0;
                                bit_cnt <= '0;
                                if (rw) begin
                                    shift   <= regs[ptr];
                                    sda_low <= ~regs[ptr][7];
                                    state   <= ST_RD_DATA;
                                end else begin
                                    sda_low <= 1'b0;
                                    state   <= ST_WR_DATA;
                                end
                            end
                        end
                    end
                    ST_WR_DATA: begin
                        if (scl_rise) begin
                            shift   <= {shift[6:0], sda_s};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                state <= ST_WR_ACK;
                            end
                        end
                    end
                    ST_WR_ACK: begin
                        if (scl_fall) begin
                            if (!ack_on) begin
                                ack_on      <= 1'b1;
                                sda_low     <= 1'b1;
                                wr_strobe_q <= 1'b1;
                                wr_index_q  <= ptr;
                                wr_data_q   <= shift;
                            end else begin
                                ack_on  <= 1'b0;
                                sda_low <= 1'b0;
                                ptr     <= ptr + 1'b1;
                                state   <= ST_WR_DATA;
                            end
                        end
                    end
                    ST_RD_DATA: begin
                        if (scl_fall) begin
                            if (bit_cnt == 3'd7) begin
                                bit_cnt <= '0;
                                sda_low <= 1'b0;
                                state   <= ST_RD_ACK;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                                shift   <= {shift[6:0], 1'b0};
                                sda_low <= ~shift[6];
                            end
                        end
                    end
                    ST_RD_ACK: begin
                        // ptr advances on the ACK rise so the following fall loads the next register.
                        if (scl_rise && !ack_on) begin
                            if (!sda_s) begin
                                ack_on <= 1'b1;
                                ptr    <= ptr + 1'b1;
                            end else begin
                                selected <= 1'b0;
                                state    <= ST_WAIT_STOP;
                            end
                        end else if (scl_fall && ack_on) begin
                            ack_on  <= 1'b0;
                            bit_cnt <= '0;
                            shift   <= regs[ptr];
                            sda_low <= ~regs[ptr][7];
                            state   <= ST_RD_DATA;
                        end
                    end
                    ST_IDLE, ST_WAIT_STOP: begin
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Commit lands one cycle after the strobe so regs_flat updates after wr_strobe.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= REG_RST;
            end
        end else if (wr_strobe_q) begin
            regs[wr_index_q] <= wr_data_q;
        end
    end

    always_comb begin
        regs_flat = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_flat[8*i +: 8] = regs[i];
        end
    end

    assign bus.regs_flat = regs_flat;
    assign bus.wr_strobe = wr_strobe_q;
    assign bus.wr_index  = wr_index_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.selected  = selected;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bit-banged I2C master bench for i2c_slave_regfile.
module tb_i2c_slave_regfile;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic m_scl_low = 1'b0;
    logic m_sda_low = 1'b0;

    wire scl;
    wire sda;
    pullup p_scl (scl);
    pullup p_sda (sda);
    assign scl = m_scl_low ? 1'b0 : 1'bz;
    assign sda = m_sda_low ? 1'b0 : 1'bz;

    i2c_slave_regfile_if #(.NUM_REGS(4)) bus ();

    i2c_slave_regfile #(
        .SLAVE_ADDR (7'h55),
        .NUM_REGS   (4),
        .REG_RST    (8'h00)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .scl     (scl),
        .sda     (sda),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int strobe_cnt = 0;
    int rogue_sda = 0;
    int sel_cycles = 0;
    logic [1:0] last_idx = '0;
    logic [7:0] last_data = '0;

    always @(negedge clk) begin
        if (bus.wr_strobe) begin
            strobe_cnt++;
            last_idx  = bus.wr_index;
            last_data = bus.wr_data;
        end
        if (sda === 1'b0 && !m_sda_low) rogue_sda++;
        if (bus.selected) sel_cycles++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_sda_low = 1'b0;
        clks(5);
        m_scl_low = 1'b0;
        clks(10);
        m_sda_low = 1'b1;
        clks(10);
        m_scl_low = 1'b1;
        clks(2);
    endtask

    task automatic i2c_stop();
        m_sda_low = 1'b1;
        clks(8);
        m_scl_low = 1'b0;
        clks(10);
        m_sda_low = 1'b0;
        clks(20);
    endtask

    task automatic write_bit(input logic b);
        m_sda_low = ~b;
        clks(8);
        m_scl_low = 1'b0;
        clks(10);
        m_scl_low = 1'b1;
        clks(2);
    endtask

    task automatic read_bit(output logic v);
        m_sda_low = 1'b0;
        clks(8);
        m_scl_low = 1'b0;
        clks(5);
        v = sda;
        clks(5);
        m_scl_low = 1'b1;
        clks(2);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(input logic do_ack, output logic [7:0] d);
        logic v;
        for (int i = 7; i >= 0; i--) begin
            read_bit(v);
            d[i] = v;
        end
        write_bit(~do_ack);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic       ack;
        logic       v;
        logic [7:0] d;
        int         s0;
        int         r0;
        int         c0;

        // Reset and idle bus
        clks(5);
        reset_n = 1'b1;
        clks(10);
        chk("rst_sda", sda, 1);
        chk("rst_selected", bus.selected, 0);
        chk("rst_regs", bus.regs_flat, 32'h0000_0000);
        chk("rst_strobes", strobe_cnt, 0);

        // Single write of 8'hAA
        s0 = strobe_cnt;
        i2c_start();
        write_byte(8'hAA, ack);
        chk("w1_addr_ack", ack, 0);
        chk("w1_selected", bus.selected, 1);
        write_byte(8'hAA, ack);
        chk("w1_data_ack", ack, 0);
        i2c_stop();
        chk("w1_strobes", strobe_cnt - s0, 1);
        chk("w1_index", last_idx, 0);
        chk("w1_data", last_data, 8'hAA);
        chk("w1_regs", bus.regs_flat, 32'h0000_00AA);
        chk("w1_sel_after_stop", bus.selected, 0);

        // One-byte read with NACK
        i2c_start();
        write_byte(8'hAB, ack);
        chk("r1_addr_ack", ack, 0);
        read_byte(1'b0, d);
        chk("r1_data", d, 8'hAA);
        chk("r1_sel_after_nack", bus.selected, 0);
        chk("r1_sda_released", sda, 1);
        i2c_stop();

        // Five bytes wrap the pointer over four registers
        s0 = strobe_cnt;
        i2c_start();
        write_byte(8'hAA, ack);
        chk("w5_addr_ack", ack, 0);
        for (int i = 1; i <= 5; i++) begin
            write_byte(8'(i), ack);
            chk("w5_data_ack", ack, 0);
        end
        i2c_stop();
        chk("w5_strobes", strobe_cnt - s0, 5);
        chk("w5_regs", bus.regs_flat, 32'h0403_0205);

        // Foreign address 7'h2A is ignored
        s0 = strobe_cnt;
        r0 = rogue_sda;
        c0 = sel_cycles;
        i2c_start();
        write_byte(8'h54, ack);
        chk("na_addr_nack", ack, 1);
        write_byte(8'h5A, ack);
        chk("na_data_nack", ack, 1);
        chk("na_selected", sel_cycles - c0, 0);
        i2c_stop();
        chk("na_sda_never_driven", rogue_sda - r0, 0);
        chk("na_strobes", strobe_cnt - s0, 0);
        chk("na_regs", bus.regs_flat, 32'h0403_0205);

        // Burst read after writing 11,22,33,44
        i2c_start();
        write_byte(8'hAA, ack);
        for (int i = 0; i < 4; i++) begin
            d = 8'h11 * 8'(i + 1);
            write_byte(d, ack);
            chk("bw_ack", ack, 0);
        end
        i2c_stop();
        chk("bw_regs", bus.regs_flat, 32'h4433_2211);
        i2c_start();
        write_byte(8'hAB, ack);
        chk("br_addr_ack", ack, 0);
        read_byte(1'b1, d);
        chk("br_byte0", d, 8'h11);
        read_byte(1'b1, d);
        chk("br_byte1", d, 8'h22);
        read_byte(1'b0, d);
        chk("br_byte2", d, 8'h33);
        chk("br_sel_after_nack", bus.selected, 0);
        chk("br_sda_released", sda, 1);
        read_bit(v);
        chk("br_wait_stop_quiet", v, 1);
        i2c_stop();

        // Reset while the slave drives a 0 data bit (reg0 = 8'h11)
        i2c_start();
        write_byte(8'hAB, ack);
        chk("rr_addr_ack", ack, 0);
        read_bit(v);
        read_bit(v);
        clks(4);
        chk("rr_slave_driving", sda, 0);
        reset_n = 1'b0;
        clks(1);
        chk("rr_sda_released", sda, 1);
        chk("rr_regs_cleared", bus.regs_flat, 32'h0000_0000);
        chk("rr_selected", bus.selected, 0);
        clks(2);
        reset_n = 1'b1;
        clks(2);
        i2c_stop();

        // Clean write then read-back after reset
        s0 = strobe_cnt;
        i2c_start();
        write_byte(8'hAA, ack);
        chk("pw_addr_ack", ack, 0);
        write_byte(8'hAA, ack);
        chk("pw_data_ack", ack, 0);
        i2c_stop();
        chk("pw_strobes", strobe_cnt - s0, 1);
        chk("pw_regs", bus.regs_flat, 32'h0000_00AA);
        i2c_start();
        write_byte(8'hAB, ack);
        read_byte(1'b0, d);
        chk("pw_readback", d, 8'hAA);
        i2c_stop();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
